// File: rtl/hls_run_sequencer.sv
// Host-side job sequencer for one HLS `main` accelerator: preload the array over the slave RAM
// port, pulse start, time the run against a timeout, then stream the results back out.
module hls_run_sequencer #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned SIZE_W    = 7,
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned N_WORDS   = 100,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 200000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_BITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_BITS-1:0]   out_data,
    output logic                   busy,
    output logic                   job_done,
    output logic                   timeout_err,
    output logic [31:0]            cycle_count,
    output logic                   start_port,
    input  logic                   done_port,
    output logic [1:0]             S_oe_ram,
    output logic [1:0]             S_we_ram,
    output logic [2*ADDR_W-1:0]    S_addr_ram,
    output logic [2*DATA_W-1:0]    S_Wdata_ram,
    output logic [2*SIZE_W-1:0]    S_data_ram_size,
    input  logic [2*DATA_W-1:0]    Sout_Rdata_ram,
    input  logic [1:0]             Sout_DataRdy
);

    localparam int unsigned IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned WORD_BYTES = WORD_BITS / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StRead,
        StFin,
        StErr
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            cycle_q, cycle_d;
    logic                   terr_q, terr_d;
    logic                   oe_q, oe_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_BITS-1:0]   wdata_q, wdata_d;
    logic                   ovalid_q, ovalid_d;
    logic [WORD_BITS-1:0]   odata_q, odata_d;

    logic                   ack;
    logic [ADDR_W-1:0]      idx_addr;
    logic [31:0]            cycle_inc;
    logic [SIZE_W-1:0]      size_lane0;
    logic                   unused_inputs;

    assign ack       = Sout_DataRdy[0];
    assign idx_addr  = ADDR_W'(BASE_ADDR + 32'(idx_q) * WORD_BYTES);
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;

    assign unused_inputs = ^{Sout_Rdata_ram[2*DATA_W-1:WORD_BITS], Sout_DataRdy[1]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cycle_d  = cycle_q;
        terr_d   = terr_q;
        oe_d     = oe_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    cycle_d = '0;
                    terr_d  = 1'b0;
                end
            end
            StLoad: begin
                if (we_q) begin
                    if (ack) begin
                        we_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = StStart;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else if (in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = idx_addr;
                    wdata_d = in_data;
                end
            end
            StStart: begin
                cycle_d = 32'd1;
                state_d = StRun;
            end
            StRun: begin
                // Done beats a coincident timeout; on abort the count stays at TIMEOUT.
                if (done_port) begin
                    cycle_d = cycle_inc;
                    state_d = StRead;
                    idx_d   = '0;
                end else if (cycle_q >= TIMEOUT) begin
                    state_d = StErr;
                    terr_d  = 1'b1;
                end else begin
                    cycle_d = cycle_inc;
                end
            end
            StRead: begin
                if (ovalid_q) begin
                    if (out_ready) begin
                        ovalid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = StFin;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else if (oe_q) begin
                    if (ack) begin
                        oe_d     = 1'b0;
                        ovalid_d = 1'b1;
                        odata_d  = Sout_Rdata_ram[WORD_BITS-1:0];
                    end
                end else begin
                    oe_d   = 1'b1;
                    addr_d = idx_addr;
                end
            end
            StFin, StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cycle_q  <= '0;
            terr_q   <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cycle_q  <= cycle_d;
            terr_q   <= terr_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    assign size_lane0 = (oe_q || we_q) ? SIZE_W'(WORD_BITS) : '0;

    assign in_ready        = (state_q == StLoad) && !we_q;
    assign out_valid       = ovalid_q;
    assign out_data        = odata_q;
    assign busy            = (state_q != StIdle);
    assign job_done        = (state_q == StFin) || (state_q == StErr);
    assign timeout_err     = terr_q;
    assign cycle_count     = cycle_q;
    assign start_port      = (state_q == StStart);
    assign S_oe_ram        = {1'b0, oe_q};
    assign S_we_ram        = {1'b0, we_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, DATA_W'(wdata_q)};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, size_lane0};

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer: a table of full jobs against a slave-RAM/sorting
// accelerator model, plus hand-written timeout, coincidence and mid-job reset sequences.
module tb_hls_run_sequencer;

    localparam int N = 100;
    localparam int NB = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: default parameters
    logic          reset, cmd_start, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_data, out_data, cycle_count;
    logic          busy, job_done, timeout_err, start_port, done_port;
    logic [1:0]    S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [19:0]   S_addr_ram;
    logic [127:0]  S_Wdata_ram, Sout_Rdata_ram;
    logic [13:0]   S_data_ram_size;

    // Instance B: short timeout, short job
    logic          reset_b, cmd_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [31:0]   in_data_b, out_data_b, cycle_count_b;
    logic          busy_b, job_done_b, timeout_err_b, start_port_b, done_b;
    logic [1:0]    S_oe_b, S_we_b, Sout_DataRdy_b;
    logic [19:0]   S_addr_b;
    logic [127:0]  S_Wdata_b, Sout_Rdata_b;
    logic [13:0]   S_size_b;

    hls_run_sequencer dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .job_done(job_done), .timeout_err(timeout_err),
        .cycle_count(cycle_count), .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    hls_run_sequencer #(.N_WORDS(NB), .TIMEOUT(50)) dut_b (
        .clock(clock), .reset(reset_b), .cmd_start(cmd_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .busy(busy_b), .job_done(job_done_b), .timeout_err(timeout_err_b),
        .cycle_count(cycle_count_b), .start_port(start_port_b), .done_port(done_b),
        .S_oe_ram(S_oe_b), .S_we_ram(S_we_b), .S_addr_ram(S_addr_b),
        .S_Wdata_ram(S_Wdata_b), .S_data_ram_size(S_size_b),
        .Sout_Rdata_ram(Sout_Rdata_b), .Sout_DataRdy(Sout_DataRdy_b)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---- slave RAM + sorting accelerator model for instance A ----
    logic [31:0] mem [0:255];
    int   ack_dly = 0;
    int   done_dly = 1000000;
    int   wait_cnt = 0;
    logic done_force = 1'b0;
    logic acc_on = 1'b0;
    int   acc_cnt = 0;
    int   wr_cnt = 0, addr_err = 0, port_err = 0, overlap = 0;
    int   done_pulses = 0, start_pulses = 0;
    int   oe_cnt_b = 0;
    logic req;

    assign req            = S_oe_ram[0] | S_we_ram[0];
    assign Sout_DataRdy   = {1'b0, req && (wait_cnt >= ack_dly)};
    assign Sout_Rdata_ram = {96'd0, mem[S_addr_ram[9:2]]};
    assign done_port      = done_force || (acc_on && acc_cnt == done_dly);

    assign Sout_DataRdy_b = {1'b0, S_oe_b[0] | S_we_b[0]};
    assign Sout_Rdata_b   = {96'd0, 32'h100 + {22'd0, S_addr_b[9:0]}};

    always @(posedge clock) begin
        wait_cnt <= (req && !Sout_DataRdy[0]) ? wait_cnt + 1 : 0;
        if (S_we_ram[0] && Sout_DataRdy[0]) begin
            mem[S_addr_ram[9:2]] = S_Wdata_ram[31:0];
            if (S_addr_ram[9:0] != 10'((wr_cnt % N) * 4)) addr_err++;
            wr_cnt++;
        end
        if (S_oe_ram[0] && S_we_ram[0]) overlap++;
        if (req && (S_oe_ram[1] || S_we_ram[1] || S_addr_ram[19:10] != 10'd0 ||
                    S_data_ram_size != 14'd32 ||
                    (S_we_ram[0] && S_Wdata_ram[127:32] != 96'd0)))
            port_err++;
        if (job_done) done_pulses++;
        if (start_port) start_pulses++;
        if (S_oe_b[0]) oe_cnt_b++;
        if (start_port) begin
            acc_on  <= 1'b1;
            acc_cnt <= 1;
        end else if (acc_on && done_port) begin
            acc_on <= 1'b0;
            for (int a = 0; a < N - 1; a++)
                for (int b = 0; b < N - 1 - a; b++)
                    if (mem[b] > mem[b+1]) begin
                        logic [31:0] t;
                        t = mem[b];
                        mem[b] = mem[b+1];
                        mem[b+1] = t;
                    end
        end else if (acc_on) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    typedef struct {
        int          ack_dly;
        bit          in_gap;
        bit          out_bp;
        int          done_dly;
        int          mul;       // 0: descending off+N..off+1, else off+(i*mul)%N
        logic [31:0] off;
        bit          noise;     // spurious done in LOAD, cmd_start pulses in RUN
        logic [31:0] exp_base;  // expected sorted output i is exp_base+i
        logic [31:0] exp_cc;
    } job_t;

    function automatic logic [31:0] in_val(input job_t j, input int i);
        if (j.mul == 0) return j.off + 32'(N - i);
        return j.off + 32'((i * j.mul) % N);
    endfunction

    task automatic run_job(input job_t j, input int stop_at, output bit stopped);
        int d0, s0, w0, ae0, pe0, ov0, bud, oi, cyc, limit;
        bit hs, prev_stall;
        logic [31:0] prev_data;
        stopped = 1'b0;
        d0 = done_pulses; s0 = start_pulses; w0 = wr_cnt;
        ae0 = addr_err; pe0 = port_err; ov0 = overlap;
        ack_dly = j.ack_dly;
        done_dly = j.done_dly;
        out_ready = 1'b1;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("busy_after_cmd", busy, 1);
        check("cc_cleared", cycle_count, 0);
        check("terr_cleared", timeout_err, 0);

        for (int i = 0; i < N; i++) begin
            if (j.in_gap && (i % 2 == 1)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data = in_val(j, i);
            bud = 0;
            hs = 1'b0;
            while (!hs && bud < 20) begin
                hs = in_ready;
                tick();
                bud++;
            end
            in_valid = 1'b0;
            if (!hs) check("load_handshake", 0, 1);
            if (j.noise && i == 10) begin
                done_force = 1'b1;
                tick();
                done_force = 1'b0;
            end
        end

        bud = 0;
        while (!start_port && bud < 20) begin
            tick();
            bud++;
        end
        check("start_seen", start_port, 1);
        check("writes_count", 64'(wr_cnt - w0), N);
        check("write_addr", 64'(addr_err - ae0), 0);
        tick();
        check("start_one_cycle", start_port, 0);
        if (j.noise) begin
            cmd_start = 1'b1;
            tick();
            tick();
            cmd_start = 1'b0;
        end

        oi = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        limit = j.done_dly + N * 12 + 100;
        while (oi < N && cyc < limit) begin
            out_ready = j.out_bp ? (cyc % 4 == 3) : 1'b1;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (stop_at >= 0 && oi == stop_at && S_oe_ram[0]) begin
                stopped = 1'b1;
                return;
            end
            if (out_valid && out_ready) begin
                check("out_data", out_data, j.exp_base + 32'(oi));
                oi++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("read_count", 64'(oi), N);
        check("job_done_pulse", job_done, 1);
        check("terr_ok", timeout_err, 0);
        tick();
        check("idle_after", busy, 0);
        check("job_done_dropped", job_done, 0);
        check("done_pulses", 64'(done_pulses - d0), 1);
        check("start_pulses", 64'(start_pulses - s0), 1);
        check("cycle_count", cycle_count, j.exp_cc);
        check("oe_we_overlap", 64'(overlap - ov0), 0);
        check("port_fields", 64'(port_err - pe0), 0);
        tick(); tick(); tick();
        check("cycle_count_hold", cycle_count, j.exp_cc);
    endtask

    task automatic run_b(input bit coincide);
        int o0, bud, oi;
        o0 = oe_cnt_b;
        cmd_b = 1'b1;
        tick();
        cmd_b = 1'b0;
        check("b_terr_cleared", timeout_err_b, 0);
        bud = 0;
        while (!start_port_b && bud < 40) begin
            tick();
            bud++;
        end
        check("b_start_seen", start_port_b, 1);
        repeat (50) tick();
        check("b_cc_at_50", cycle_count_b, 50);
        check("b_still_run", job_done_b, 0);
        done_b = coincide;
        tick();
        done_b = 1'b0;
        if (!coincide) begin
            check("b_timeout_done", job_done_b, 1);
            check("b_timeout_err", timeout_err_b, 1);
            check("b_timeout_cc", cycle_count_b, 50);
            check("b_no_oe", 64'(oe_cnt_b - o0), 0);
            tick();
            check("b_idle", busy_b, 0);
            check("b_terr_sticky", timeout_err_b, 1);
        end else begin
            check("b_coin_no_done", job_done_b, 0);
            check("b_coin_terr", timeout_err_b, 0);
            check("b_coin_cc", cycle_count_b, 51);
            check("b_coin_busy", busy_b, 1);
            oi = 0;
            bud = 0;
            while (oi < NB && bud < 60) begin
                if (out_valid_b) begin
                    check("b_out_data", out_data_b, 32'h100 + 32'(4 * oi));
                    oi++;
                end
                tick();
                bud++;
            end
            check("b_read_count", 64'(oi), NB);
            check("b_job_done", job_done_b, 1);
            check("b_terr_final", timeout_err_b, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[4];
        job_t stop_job;
        bit stopped;
        int d0;

        jobs[0] = '{ack_dly: 0, in_gap: 0, out_bp: 0, done_dly: 5000, mul: 0, off: 32'h0,
                    noise: 0, exp_base: 32'd1, exp_cc: 32'd5001};
        jobs[1] = '{ack_dly: 2, in_gap: 1, out_bp: 1, done_dly: 10, mul: 37,
                    off: 32'hA500_0000, noise: 0, exp_base: 32'hA500_0000, exp_cc: 32'd11};
        jobs[2] = '{ack_dly: 1, in_gap: 0, out_bp: 0, done_dly: 1, mul: 13, off: 32'h7F00,
                    noise: 0, exp_base: 32'h7F00, exp_cc: 32'd2};
        jobs[3] = '{ack_dly: 0, in_gap: 1, out_bp: 0, done_dly: 30, mul: 0,
                    off: 32'hFFFF_FF00, noise: 1, exp_base: 32'hFFFF_FF01, exp_cc: 32'd31};

        reset = 1'b0; reset_b = 1'b0;
        cmd_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cmd_b = 1'b0; in_valid_b = 1'b1; in_data_b = 32'h5A; out_ready_b = 1'b1; done_b = 1'b0;
        tick();
        tick();
        check("reset_outputs_zero", |{in_ready, out_valid, out_data, busy, job_done, timeout_err,
              cycle_count, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
              S_data_ram_size}, 0);
        check("reset_busy_b", busy_b, 0);
        reset = 1'b1;
        reset_b = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) run_job(jobs[k], -1, stopped);

        // Mid-READ reset while word 37 is being fetched
        stop_job = jobs[0];
        stop_job.done_dly = 20;
        d0 = done_pulses;
        run_job(stop_job, 37, stopped);
        check("reached_idx37", stopped, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midjob_reset_zero", |{in_ready, out_valid, out_data, busy, job_done, timeout_err,
              cycle_count, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
              S_data_ram_size}, 0);
        tick();
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("no_done_after_reset", 64'(done_pulses - d0), 0);
        check("idle_after_reset", busy, 0);
        run_job(jobs[2], -1, stopped);

        run_b(1'b0);
        run_b(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
